operand_issue_stage: RTL and testbench
======================================

// Module: operand_issue_stage
// PURPOSE
//   Upstream feeder for the 2-operand registered result stage (data1_in/data2_in/valid_in/ready_out).
//   Buffers operand pairs from a source in a small FIFO.
//   Issues them to the result stage over a registered valid/ready handshake.
//   Enforces a programmable minimum gap between issues.
//   Tracks FIFO occupancy and the total number of issued pairs.
// PARAMETERS
//   W      1  width of each operand (data1, data2)
//   DEPTH  4  FIFO entries; power of 2, >= 2
//   GAP    0  idle cycles forced after each accepted issue; 0 = back-to-back
// PORTS
//   clk           in   1               clock, all logic on posedge
//   rst           in   1               reset, asynchronous, active-high
//   flush         in   1               synchronous clear of FIFO, FSM and output valid
//   src_valid     in   1               source pair valid
//   src_data1     in   W               source operand 1
//   src_data2     in   W               source operand 2
//   src_ready     out  1               FIFO can accept; equals !full
//   dst_valid     out  1               registered; pair presented to result stage
//   dst_data1     out  W               registered operand 1 -> data1_in
//   dst_data2     out  W               registered operand 2 -> data2_in
//   dst_ready     in   1               result stage accepts (tie to ready_out)
//   level         out  $clog2(DEPTH+1) FIFO occupancy, 0..DEPTH
//   issued_count  out  16              accepted dst transfers, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset values:
//   - dst_valid=0, dst_data1/2=0, level=0, issued_count=0, src_ready=1.
//   - FSM=IDLE, gap counter=0.
//   Write:
//   - A write occurs when src_valid && src_ready && !flush.
//   - No bypass: when full, src_ready=0 even if a pop occurs in the same cycle.
//   Pop:
//   - A FIFO pop happens only when the FSM loads the output register.
//   - level updates on every edge: +1 on write, -1 on pop, unchanged on both or neither.
//   FSM states:
//   - IDLE:
//       - If level>0: pop the head into dst_data1/2, set dst_valid=1, go to ISSUE.
//   - ISSUE:
//       - dst_valid and the data are held stable while dst_ready=0.
//       - On dst_ready=1: issued_count+1.
//           - GAP>0: dst_valid=0, gap counter=GAP, go to GAP.
//           - GAP=0 and level>0: pop the next pair in the same edge, dst_valid stays 1, stay in ISSUE.
//           - GAP=0 and level=0: dst_valid=0, go to IDLE.
//   - GAP:
//       - Counter decrements each cycle with dst_valid=0.
//       - When the counter reaches 1, go to IDLE.
//       - Minimum spacing between transfers is therefore GAP+2 cycles; it is GAP+1 when GAP=0 (full rate, 1/cycle).
//   Latency:
//   - A pair written at edge k into an empty FIFO in IDLE shows dst_valid=1 after edge k+1.
//   flush (highest priority after rst):
//   - Empties the FIFO (level=0) and discards a same-cycle write.
//   - dst_valid=0, FSM=IDLE, gap counter=0.
//   - issued_count is unchanged, including an accept coinciding with flush.
//   Reset mid-operation:
//   - Asynchronous return to the reset values; the in-flight pair is lost.
//   Pointers:
//   - log2(DEPTH) bits, natural wrap.
//   - Full/empty are derived from level.
// TESTING
//   1. Reset:
//      - Stimulus: reset, then 3 idle cycles.
//      - Required: dst_valid=0, src_ready=1, level=0, issued_count=0.
//   2. Single pair, GAP=0:
//      - Stimulus: write (1,1) with dst_ready=1.
//      - Required: dst_valid high exactly 1 cycle, one edge after the write, with data (1,1); issued_count=1.
//   3. Fill and stall:
//      - Stimulus: dst_ready=0, 6 writes, DEPTH=4.
//      - Required: 1 pair in the output register, 4 in the FIFO.
//      - Required: src_ready=0 and level=4; the 6th write is not accepted.
//      - Then dst_ready=1: 5 pairs drain in order, 1 per cycle.
//   4. GAP=2:
//      - Stimulus: 3 queued pairs, dst_ready=1.
//      - Required: transfers on cycles t, t+4, t+8; issued_count=3.
//   5. Flush:
//      - Stimulus: level=3 and dst_valid=1, then assert flush with src_valid=1.
//      - Required: next cycle level=0, dst_valid=0, issued_count unchanged.
//   6. Counter wrap:
//      - Stimulus: preload or run 65536 transfers.
//      - Required: issued_count 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/operand_issue_stage.sv
// Operand-pair issue stage: small FIFO feeding a registered valid/ready output
// toward the 2-operand result stage, with an optional enforced gap between issues.
module operand_issue_stage #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         src_valid,
    input  logic [W-1:0]                 src_data1,
    input  logic [W-1:0]                 src_data2,
    output logic                         src_ready,
    output logic                         dst_valid,
    output logic [W-1:0]                 dst_data1,
    output logic [W-1:0]                 dst_data2,
    input  logic                         dst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  issued_count
);

    localparam int  AW      = $clog2(DEPTH);
    localparam int  LW      = $clog2(DEPTH + 1);
    localparam int  GW      = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam bit  HAS_GAP = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                vld_d;
    logic                load;
    logic                accept;
    logic                wr;
    logic                full;
    logic                empty;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [W-1:0]        mem1 [DEPTH];
    logic [W-1:0]        mem2 [DEPTH];

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign src_ready = !full;
    assign wr        = src_valid && src_ready && !flush;

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        vld_d     = dst_valid;
        load      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    vld_d   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dst_ready) begin
                    accept = 1'b1;
                    if (HAS_GAP) begin
                        vld_d     = 1'b0;
                        gap_cnt_d = GW'(GAP);
                        state_d   = ST_GAP;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= GW'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // flush overrides everything except reset; the accept is not counted
        if (flush) begin
            state_d   = ST_IDLE;
            gap_cnt_d = '0;
            vld_d     = 1'b0;
            load      = 1'b0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            dst_valid    <= 1'b0;
            issued_count <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            dst_valid <= vld_d;
            if (accept)
                issued_count <= issued_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (load)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr, load})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage array carries data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (wr) begin
            mem1[wr_ptr] <= src_data1;
            mem2[wr_ptr] <= src_data2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_data1 <= '0;
            dst_data2 <= '0;
        end else if (load) begin
            dst_data1 <= mem1[rd_ptr];
            dst_data2 <= mem2[rd_ptr];
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: one GAP=0 instance and one GAP=2 instance.
module tb_operand_issue_stage;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;

    logic         src_valid, src_ready, dst_valid, dst_ready;
    logic [W-1:0] src_data1, src_data2, dst_data1, dst_data2;
    logic [2:0]   level;
    logic [15:0]  issued_count;

    logic         g_src_valid, g_src_ready, g_dst_valid, g_dst_ready;
    logic [W-1:0] g_src_data1, g_src_data2, g_dst_data1, g_dst_data2;
    logic [2:0]   g_level;
    logic [15:0]  g_issued_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    operand_issue_stage #(.W(W), .DEPTH(DEPTH), .GAP(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_data1(src_data1), .src_data2(src_data2),
        .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data1(dst_data1), .dst_data2(dst_data2),
        .dst_ready(dst_ready), .level(level), .issued_count(issued_count)
    );

    operand_issue_stage #(.W(W), .DEPTH(DEPTH), .GAP(2)) u_gap (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(g_src_valid), .src_data1(g_src_data1), .src_data2(g_src_data2),
        .src_ready(g_src_ready),
        .dst_valid(g_dst_valid), .dst_data1(g_dst_data1), .dst_data2(g_dst_data2),
        .dst_ready(g_dst_ready), .level(g_level), .issued_count(g_issued_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int t_acc [3];
        int d_acc [3];
        int n_acc;
        int cyc;

        rst = 1'b1; flush = 1'b0;
        src_valid = 1'b0; src_data1 = '0; src_data2 = '0; dst_ready = 1'b0;
        g_src_valid = 1'b0; g_src_data1 = '0; g_src_data2 = '0; g_dst_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_dst_valid", dst_valid, 0);
        check("rst_src_ready", src_ready, 1);
        check("rst_level", level, 0);
        check("rst_issued", issued_count, 0);
        check("rst_dst_data1", dst_data1, 0);

        // Single pair, full rate
        src_valid = 1'b1; src_data1 = 4'd1; src_data2 = 4'd1; dst_ready = 1'b1;
        step();
        src_valid = 1'b0;
        check("single_not_yet_valid", dst_valid, 0);
        check("single_level1", level, 1);
        step();
        check("single_valid", dst_valid, 1);
        check("single_data1", dst_data1, 1);
        check("single_data2", dst_data2, 1);
        step();
        check("single_valid_drop", dst_valid, 0);
        check("single_issued", issued_count, 1);

        // Fill and stall, then drain in order
        dst_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            src_valid = 1'b1;
            src_data1 = 4'(i + 2);
            src_data2 = 4'(10 - i);
            if (i == 5) check("fill_src_ready_low", src_ready, 0);
            step();
        end
        src_valid = 1'b0;
        check("fill_level4", level, 4);
        check("fill_src_ready", src_ready, 0);
        check("fill_head_valid", dst_valid, 1);
        check("fill_head_data", dst_data1, 2);
        dst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", dst_valid, 1);
            check("drain_data1", dst_data1, 32'(i + 2));
            check("drain_data2", dst_data2, 32'(10 - i));
            step();
        end
        check("drain_done_valid", dst_valid, 0);
        check("drain_issued", issued_count, 6);
        check("drain_level", level, 0);

        // GAP=2 instance: three queued pairs, accepts 4 cycles apart
        for (int i = 0; i < 3; i++) begin
            g_src_valid = 1'b1;
            g_src_data1 = 4'(i + 5);
            g_src_data2 = 4'(i + 9);
            step();
        end
        g_src_valid = 1'b0;
        g_dst_ready = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 14; c++) begin
            if (g_dst_valid && n_acc < 3) begin
                t_acc[n_acc] = c;
                d_acc[n_acc] = int'(g_dst_data1);
                n_acc++;
            end
            step();
        end
        check("gap_n_accepts", n_acc, 3);
        check("gap_t0", t_acc[0], 0);
        check("gap_t1", t_acc[1], 4);
        check("gap_t2", t_acc[2], 8);
        check("gap_d0", d_acc[0], 5);
        check("gap_d1", d_acc[1], 6);
        check("gap_d2", d_acc[2], 7);
        check("gap_issued", g_issued_count, 3);

        // Flush with a coinciding write and accept
        dst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b1;
            src_data1 = 4'(i + 1);
            src_data2 = 4'(i + 1);
            step();
        end
        check("preflush_level", level, 3);
        check("preflush_valid", dst_valid, 1);
        flush = 1'b1; src_valid = 1'b1; dst_ready = 1'b1;
        step();
        flush = 1'b0; src_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_valid", dst_valid, 0);
        check("flush_issued", issued_count, 6);
        check("flush_src_ready", src_ready, 1);
        step();
        check("flush_stays_idle", dst_valid, 0);

        // Stream at full rate until issued_count wraps
        src_valid = 1'b1; src_data1 = 4'd3; src_data2 = 4'd4; dst_ready = 1'b1;
        cyc = 0;
        while (issued_count != 16'hFFFF && cyc < 70000) begin
            step();
            cyc++;
        end
        check("wrap_reached_ffff", issued_count, 32'hFFFF);
        check("wrap_stream_valid", dst_valid, 1);
        step();
        check("wrap_to_zero", issued_count, 0);

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        check("async_rst_valid", dst_valid, 0);
        check("async_rst_level", level, 0);
        check("async_rst_issued", issued_count, 0);
        check("async_rst_data", dst_data1, 0);
        src_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_src_ready", src_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
